// File: rtl/cdc_handshake_rx_pkg.sv
// Shared definitions for the clk_b-side handshake receiver and its synchronizer.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        ACK      = 2'd2,
        WAIT_LOW = 2'd3
    } hs_state_t;

    localparam int CDC_SYNC_STAGES = 2;
    localparam int CDC_HS_TIMEOUT  = 64;
    localparam int CDC_CNT_W       = 8;

endpackage

// File: rtl/cdc_handshake_rx_if.sv
// Source-facing req/data/ack plus downstream valid/ready bundle for cdc_handshake_rx.
interface cdc_handshake_rx_if
    import cdc_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic                 req_a;
    logic [WIDTH-1:0]     data_a;
    logic                 valid_b;
    logic                 ready_b;
    logic [WIDTH-1:0]     data_b;
    logic                 ack_b;
    logic                 err_b;
    logic [CDC_CNT_W-1:0] xfer_cnt;

    modport master (
        output req_a, data_a, ready_b,
        input  valid_b, data_b, ack_b, err_b, xfer_cnt
    );

    modport slave (
        input  req_a, data_a, ready_b,
        output valid_b, data_b, ack_b, err_b, xfer_cnt
    );
endinterface

// File: rtl/cdc_handshake_rx_sync_nff.sv
// Purpose: STAGES-deep 1-bit flop-chain synchronizer, async active-low reset to 0.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; free-running.
module sync_nff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];
endmodule

// File: rtl/cdc_handshake_rx.sv
// Purpose: clk_b-side 4-phase req/ack receiver with valid/ready output and stuck-req timeout.
// Latency: data_b/valid_b update SYNC_STAGES+1 edges after req_a is first sampled high.
// Backpressure: holds valid_b/data_b and withholds ack_b until ready_b; source stalls on ack.
module cdc_handshake_rx
    import cdc_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = CDC_SYNC_STAGES,
    parameter int TIMEOUT     = CDC_HS_TIMEOUT
) (
    input logic               clk_b,
    input logic               rst_b,
    cdc_handshake_rx_if.slave bus
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SW = $clog2(SYNC_STAGES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic                 req_s;
    hs_state_t            state, state_nxt;
    logic [WIDTH-1:0]     data_q, data_nxt;
    logic                 valid_q, valid_nxt;
    logic                 ack_q, ack_nxt;
    logic                 err_q, err_nxt;
    logic [CDC_CNT_W-1:0] xfer_q, xfer_nxt;
    logic [TW-1:0]        to_cnt, to_cnt_nxt;
    logic [SW-1:0]        settle_cnt;
    logic                 settled;
    logic                 timeout_hit;

    sync_nff #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk_b),
        .rst_n (rst_b),
        .d     (bus.req_a),
        .q     (req_s)
    );

    // The chain resets to 0, so req_s only reflects the real req_a once it has
    // been flushed; leaving WAIT_LOW earlier would capture a req held across reset.
    assign settled     = (settle_cnt == SW'(SYNC_STAGES));
    assign timeout_hit = (TIMEOUT > 0) && (to_cnt == TO_LAST);

    always_ff @(posedge clk_b or negedge rst_b) begin
        if (!rst_b) begin
            settle_cnt <= '0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk_b or negedge rst_b) begin
        if (!rst_b) begin
            state   <= WAIT_LOW;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            xfer_q  <= '0;
            to_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            ack_q   <= ack_nxt;
            err_q   <= err_nxt;
            xfer_q  <= xfer_nxt;
            to_cnt  <= to_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        data_nxt   = data_q;
        valid_nxt  = valid_q;
        ack_nxt    = ack_q;
        err_nxt    = 1'b0;
        xfer_nxt   = xfer_q;
        to_cnt_nxt = to_cnt;
        case (state)
            IDLE: begin
                if (req_s) begin
                    state_nxt = HOLD;
                    data_nxt  = bus.data_a;
                    valid_nxt = 1'b1;
                end
            end
            HOLD: begin
                // A req drop here is tolerated: the transfer completes and ACK exits at once.
                if (bus.ready_b) begin
                    state_nxt  = ACK;
                    valid_nxt  = 1'b0;
                    ack_nxt    = 1'b1;
                    xfer_nxt   = xfer_q + CDC_CNT_W'(1);
                    to_cnt_nxt = '0;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_nxt = IDLE;
                    ack_nxt   = 1'b0;
                end else if (timeout_hit) begin
                    state_nxt = WAIT_LOW;
                    ack_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                end else if (TIMEOUT > 0) begin
                    to_cnt_nxt = to_cnt + TW'(1);
                end
            end
            WAIT_LOW: begin
                if (!req_s && settled) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = WAIT_LOW;
        endcase
    end

    assign bus.valid_b  = valid_q;
    assign bus.data_b   = data_q;
    assign bus.ack_b    = ack_q;
    assign bus.err_b    = err_q;
    assign bus.xfer_cnt = xfer_q;
endmodule

// File: doc/cdc_handshake_rx.md
# cdc_handshake_rx

Destination-domain controller for the double-flop synchronizer path. It receives a multi-bit value from an asynchronous source using a 4-phase req/ack handshake. Only the 1-bit `req_a` passes through the flop chain; `data_a` is captured once synchronized `req` proves the data has been stable. The block sits in the clk_b domain between the async source and downstream clk_b logic, adds valid/ready backpressure, and flags sources that stop following the protocol.

## Interface
- `WIDTH`, 4: data width.
- `SYNC_STAGES`, 2: flops in the `req_a` synchronizer chain; minimum 2.
- `TIMEOUT`, 64: clk_b cycles allowed for `req` to drop after `ack_b` rises. 0 disables the check.
- `clk_b` input 1: destination clock; the only clock.
- `rst_b` input 1: asynchronous, active-low reset.
- `req_a` input 1: async request from the source; level-held.
- `data_a` input WIDTH: async data; the source holds it stable while `req_a` is 1.
- `valid_b` output 1: `data_b` is valid.
- `ready_b` input 1: downstream accepts `data_b`.
- `data_b` output WIDTH: captured data, registered.
- `ack_b` output 1: acknowledge to the source, registered, glitch-free level.
- `err_b` output 1: one-cycle pulse when a timeout occurs.
- `xfer_cnt` output 8: count of completed transfers; wraps 255 -> 0.

## Operation
- `req_s` is `req_a` after SYNC_STAGES flops, each reset to 0. `data_a` is never synchronized; it is sampled only in IDLE when `req_s`=1.
- States: IDLE, HOLD, ACK, WAIT_LOW. Transitions:
  - IDLE with `req_s`=1 -> HOLD. On this edge `data_b` <= `data_a` and `valid_b` <= 1.
  - HOLD with `ready_b`=1 -> ACK. On this edge `valid_b` <= 0, `ack_b` <= 1, `xfer_cnt` += 1. HOLD waits indefinitely while `ready_b`=0, and `data_b` stays constant.
  - ACK with `req_s`=0 -> IDLE, `ack_b` <= 0.
  - ACK with `req_s`=1 and the timeout counter equal to TIMEOUT-1 (TIMEOUT>0) -> WAIT_LOW. On this edge `err_b` <= 1 for one cycle and `ack_b` <= 0.
  - WAIT_LOW with `req_s`=0 -> IDLE. No capture happens while in WAIT_LOW.
- Timeout counter: cleared on entry to ACK, increments each cycle in ACK. Its width is $clog2(TIMEOUT+1).
- Reset: the state goes to WAIT_LOW, not IDLE. A `req_a` left high across reset is therefore never captured as a new transfer.
- `data_b` is held after the handshake completes and updates only on the next capture.

## Timing
- Reset values: `valid_b`=0, `ack_b`=0, `err_b`=0, `data_b`=0, `xfer_cnt`=0, all sync flops 0, state WAIT_LOW.
- Capture latency: with `req_a` first sampled high at clk_b edge 1, `req_s`=1 after edge SYNC_STAGES, and `valid_b`/`data_b` are updated at edge SYNC_STAGES+1.
- `ack_b` rises on the edge where `valid_b && ready_b`, so `valid_b` and `ack_b` are never both 1.
- `ack_b` falls SYNC_STAGES+1 edges after `req_a` falls (ACK state), or on the timeout edge.
- Throughput: at most one transfer per 2·(SYNC_STAGES+1)+2 cycles plus the source-side round trip.
- An `ready_b` asserted while not in HOLD is ignored.
- Reset mid-operation clears all state immediately (asynchronous) and discards the pending `data_b`.
- `req_a` dropping while in HOLD is a protocol violation. The required behaviour is to stay in HOLD, complete on `ready_b`, then move from ACK to IDLE on the next cycle; no error is flagged.

## Structure
- Shared package `cdc_pkg`: state enum `hs_state_t` (IDLE, HOLD, ACK, WAIT_LOW) and default constants `CDC_SYNC_STAGES`=2 and `CDC_HS_TIMEOUT`=64.
- Sub-module `sync_nff`: a SYNC_STAGES-deep 1-bit synchronizer with async active-low reset to 0. It is reusable for the source-side `ack` return path.
- The top level holds the FSM, the data register, the timeout counter and `xfer_cnt`.

## Test plan
- Reset release with `req_a`=0, then `req_a`=1 with `data_a`=4'h5 and `ready_b`=1 held: expect `valid_b` and `data_b`=5 at edge 3, `ack_b`=1 at edge 4, `xfer_cnt`=1.
- `ready_b`=0 for 10 cycles after `valid_b`: expect `valid_b` and `data_b` stable, `ack_b`=0. Then `ready_b`=1: expect `ack_b` next edge. After `req_a` falls: expect `ack_b`=0 three edges later.
- `req_a` stuck high after ack with TIMEOUT=8: expect `err_b` to pulse exactly once, 8 cycles after `ack_b` rose; `ack_b` drops on the same edge; no new capture until `req_a` goes low then high again.
- `req_a`=1 held through `rst_b` assertion and release: expect no `valid_b`. Then drop `req_a` and raise it again with `data_a`=4'hA: expect capture of A.
- 256 back-to-back transfers with random `data_a` in 2..8 and random `ready_b`: expect every value delivered in order exactly once, and `xfer_cnt` to wrap to 0.
- `rst_b` pulsed while in HOLD: expect all outputs 0 asynchronously.
